bit_packer_1024: RTL and testbench
==================================

Name: bit_packer_1024

Overview:
- Width up-converter directly upstream of the 1024-bit queue stage.
- Gathers narrow binarized activation words (64 bits by default) from the conv/bn pipeline into full 1024-bit beats.
- Presents the beats on a ready/valid port that wires straight to the queue's enq side.
- Double-buffered: sustains one input word per cycle while downstream accepts at least one beat per RATIO cycles.

Parameters:
- IN_W, 64, input word width; must divide OUT_W exactly.
- OUT_W, 1024, output beat width.
- RATIO, OUT_W/IN_W (16), words per beat; derived, not overridden.

Ports:
- clock  in  1  single clock; all state is rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- io_enq_bits  in  IN_W  input word.
- io_enq_valid  in  1  input word valid.
- io_enq_last  in  1  qualifies the word as the final word of a frame; flushes a partial beat.
- io_enq_ready  out  1  block can accept a word this cycle.
- io_deq_bits  out  OUT_W  assembled beat.
- io_deq_valid  out  1  beat valid.
- io_deq_last  out  1  beat closes a frame (copy of io_enq_last on its final word).
- io_deq_ready  in  1  downstream accepts the beat.

Behaviour:
- State:
  - asm_reg[OUT_W]: assembly register.
  - cnt[log2(RATIO)]: lane index.
  - pending, pend_last: complete beat held in asm_reg.
  - out_reg[OUT_W], out_valid, out_last: output slot.
- Reset (reset=0, asynchronous):
  - cnt=0, pending=0, out_valid=0, out_last=0.
  - asm_reg and out_reg cleared to 0.
  - Outputs during and after reset: io_deq_valid=0, io_deq_last=0, io_deq_bits=0, io_enq_ready=1.
- Reset mid-operation discards all partial and pending data. There is no drain.
- Handshakes:
  - Input accept = io_enq_valid & io_enq_ready.
  - Output fire = io_deq_valid & io_deq_ready.
  - io_enq_ready = !pending (combinational from state only; no path from io_enq_valid).
  - io_deq_bits, io_deq_valid and io_deq_last are driven directly from out_reg, out_valid and out_last.
  - Once io_deq_valid rises, io_deq_bits and io_deq_last hold stable until fire.
- Lane order: word k of a beat goes to bits [k*IN_W+IN_W-1 : k*IN_W], so the first word lands in the LSBs.
- Accept with cnt<RATIO-1 and io_enq_last=0:
  - Write the lane.
  - cnt increments.
- Beat completion occurs on accept with cnt==RATIO-1 or io_enq_last=1. The word is written into its lane and cnt returns to 0.
  - If io_enq_last=1, lanes above cnt are zero in the delivered beat. asm_reg is zeroed whenever its contents move to out_reg.
  - If the slot is free this cycle (!out_valid or fire): the assembled value goes to out_reg at the same edge. out_valid=1, out_last=io_enq_last.
  - Otherwise: pending=1 and pend_last=io_enq_last.
- While pending, out_reg is loaded from asm_reg on the first cycle the slot is free. At that edge pending clears, out_valid=1 and out_last=pend_last. io_enq_ready returns to 1 the following cycle.
- Fire with nothing to load: out_valid=0.
- Latency: final word accepted at edge N with the slot free gives io_deq_valid=1 in the cycle after edge N.
- Simultaneous fire and completion in the same cycle: the new beat replaces the old one at that edge with no bubble. out_valid stays 1.
- io_enq_last on lane 0: a one-word beat with lanes 1..RATIO-1 zero.
- Counters wrap only through completion. cnt never exceeds RATIO-1.
- X on io_enq_bits while io_enq_valid=0 must not propagate into asm_reg.

Test Plan:
1. Reset release; drive 16 words 0x0..0xF (IN_W=64), one per cycle, io_deq_ready=1 → single beat, lane k == k, io_deq_valid high exactly 1 cycle, io_deq_last=0, io_enq_ready constantly 1.
2. Stream 48 words continuously with io_deq_ready=1 → 3 beats at cycles 16, 32, 48 after the first accept; no io_enq_ready drop.
3. io_deq_ready=0; send 32 words 0x100+i → beat A held stable; after word 32, io_enq_ready=0. Raise io_deq_ready → A then B (lanes 0x110..0x11F) in order; io_enq_ready=1 the cycle after B loads.
4. Send 5 words 0xAA..0xAE, 5th with io_enq_last=1 → beat lanes 0..4 = 0xAA..0xAE, lanes 5..15 = 0, io_deq_last=1. The next beat starts at lane 0.
5. Assert reset low mid-beat after 7 words → io_deq_valid=0 and io_enq_ready=1 immediately. After release, 16 words 0x200+i produce a clean beat with no stale lanes.
6. Randomised io_enq_valid/io_deq_ready toggling over 10,000 words → scoreboard match. Never io_deq_bits change while io_deq_valid=1 & io_deq_ready=0.

Source files
------------

// File: rtl/bit_packer_1024_if.sv
// Ready/valid bundle between the conv/bn word stream and the 1024-bit queue.
// The enq side carries narrow words in; the deq side carries full beats out.
interface bit_packer_1024_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 1024
);
  logic [IN_W-1:0]  io_enq_bits;
  logic             io_enq_valid;
  logic             io_enq_last;
  logic             io_enq_ready;
  logic [OUT_W-1:0] io_deq_bits;
  logic             io_deq_valid;
  logic             io_deq_last;
  logic             io_deq_ready;

  // Environment view: produces words, consumes beats.
  modport master (
    output io_enq_bits, io_enq_valid, io_enq_last, io_deq_ready,
    input  io_enq_ready, io_deq_bits, io_deq_valid, io_deq_last
  );

  // Packer view: consumes words, produces beats.
  modport slave (
    input  io_enq_bits, io_enq_valid, io_enq_last, io_deq_ready,
    output io_enq_ready, io_deq_bits, io_deq_valid, io_deq_last
  );
endinterface

// File: rtl/bit_packer_1024.sv
// Width up-converter: packs IN_W-bit activation words into OUT_W-bit beats.
// An assembly register fills lane by lane (first word in the LSBs) while a
// separate output slot presents the previous beat, so one word per cycle is
// sustained as long as the queue takes a beat at least every RATIO cycles.
// A completed beat that cannot move to a busy slot parks in the assembly
// register (pending) and stalls the input until the slot frees up.
// IN_W must divide OUT_W exactly.
module bit_packer_1024 #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 1024
) (
  input  logic               clock,
  input  logic               reset,
  bit_packer_1024_if.slave   bus
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  logic [OUT_W-1:0] asm_reg;
  logic [OUT_W-1:0] asm_word;
  logic [OUT_W-1:0] out_reg;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             pend_last;
  logic             out_valid;
  logic             out_last;

  logic             accept;
  logic             fire;
  logic             slot_free;
  logic             complete;

  // Handshake qualifiers; input readiness depends only on registered state.
  always_comb begin
    accept    = bus.io_enq_valid & ~pending;
    fire      = out_valid & bus.io_deq_ready;
    slot_free = ~out_valid | fire;
    complete  = accept & ((cnt == LAST_LANE) | bus.io_enq_last);
  end

  // Assembly register with the incoming word dropped into its lane. Lanes
  // above cnt are always zero because asm_reg is cleared whenever it empties,
  // which is what zero-fills a beat cut short by io_enq_last.
  always_comb begin
    asm_word = asm_reg;
    if (accept) begin
      asm_word[cnt*IN_W +: IN_W] = bus.io_enq_bits;
    end
  end

  // Assembly, pending and output-slot state. A parked beat takes priority
  // for the slot; no word can be accepted while one is parked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asm_reg   <= '0;
      out_reg   <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      pend_last <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (pending && slot_free) begin
      out_reg   <= asm_reg;
      out_valid <= 1'b1;
      out_last  <= pend_last;
      asm_reg   <= '0;
      pending   <= 1'b0;
    end else if (complete && slot_free) begin
      out_reg   <= asm_word;
      out_valid <= 1'b1;
      out_last  <= bus.io_enq_last;
      asm_reg   <= '0;
      cnt       <= '0;
    end else if (complete) begin
      asm_reg   <= asm_word;
      pending   <= 1'b1;
      pend_last <= bus.io_enq_last;
      cnt       <= '0;
    end else begin
      if (accept) begin
        asm_reg <= asm_word;
        cnt     <= cnt + CNT_W'(1);
      end
      if (fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Outputs come straight from registers, so beats hold stable until taken.
  always_comb begin
    bus.io_enq_ready = ~pending;
    bus.io_deq_bits  = out_reg;
    bus.io_deq_valid = out_valid;
    bus.io_deq_last  = out_last;
  end

endmodule

// File: tb/tb_bit_packer_1024.sv
// Bench for bit_packer_1024: directed scenarios plus a randomised stream,
// with every delivered beat checked against a reference queue.
module tb_bit_packer_1024;

  localparam int IN_W  = 64;
  localparam int OUT_W = 1024;
  localparam int RATIO = OUT_W / IN_W;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  int vectors     = 0;
  int miscompares = 0;

  bit_packer_1024_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  bit_packer_1024 #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Reference state
  logic [OUT_W:0]   exp_q[$];
  int               fire_q[$];
  logic [OUT_W-1:0] m_beat = '0;
  int               m_cnt = 0;
  int               vld_cycles = 0;
  int               rdy_low = 0;
  logic             stall = 1'b0;
  logic [OUT_W-1:0] hold_bits = '0;
  logic             hold_last = 1'b0;

  task automatic chk(input string tag, input logic [OUT_W-1:0] got,
                     input logic [OUT_W-1:0] exp);
    int ln;
    vectors++;
    if (got !== exp) begin
      ln = 0;
      for (int i = 0; i < RATIO; i++) begin
        if (got[i*IN_W +: IN_W] !== exp[i*IN_W +: IN_W]) begin
          ln = i;
          break;
        end
      end
      miscompares++;
      $display("FAIL %s: lane %0d got %h expected %h", tag, ln,
               got[ln*IN_W +: IN_W], exp[ln*IN_W +: IN_W]);
    end
  endtask

  // Monitor on the falling edge: model accepts, score beats, check holds.
  always @(negedge clock) begin
    logic [OUT_W:0] e;
    if (!reset) begin
      m_beat = '0;
      m_cnt  = 0;
      exp_q.delete();
      stall  = 1'b0;
    end else begin
      if (bus.io_enq_valid && bus.io_enq_ready) begin
        m_beat[m_cnt*IN_W +: IN_W] = bus.io_enq_bits;
        if (m_cnt == RATIO - 1 || bus.io_enq_last) begin
          exp_q.push_back({bus.io_enq_last, m_beat});
          m_beat = '0;
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
      if (bus.io_deq_valid) vld_cycles++;
      if (!bus.io_enq_ready) rdy_low++;
      if (stall) begin
        chk("hold_valid", OUT_W'(bus.io_deq_valid), OUT_W'(1));
        chk("hold_bits", bus.io_deq_bits, hold_bits);
        chk("hold_last", OUT_W'(bus.io_deq_last), OUT_W'(hold_last));
      end
      if (bus.io_deq_valid && bus.io_deq_ready) begin
        fire_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", OUT_W'(1), OUT_W'(0));
        end else begin
          e = exp_q.pop_front();
          chk("beat_bits", bus.io_deq_bits, e[OUT_W-1:0]);
          chk("beat_last", OUT_W'(bus.io_deq_last), OUT_W'(e[OUT_W]));
        end
      end
      stall     = bus.io_deq_valid && !bus.io_deq_ready;
      hold_bits = bus.io_deq_bits;
      hold_last = bus.io_deq_last;
    end
  end

  // Present one word and hold it until accepted; returns the accept cycle.
  task automatic send_word(input logic [IN_W-1:0] w, input logic l,
                           output int acc_cyc);
    int n;
    bus.io_enq_bits  = w;
    bus.io_enq_last  = l;
    bus.io_enq_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.io_enq_ready && n < 400) begin
      n++;
      @(negedge clock);
    end
    if (n >= 400) chk("enq_timeout", OUT_W'(1), OUT_W'(0));
    acc_cyc = cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.io_enq_valid = 1'b0;
    bus.io_enq_last  = 1'b0;
    bus.io_enq_bits  = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    bus.io_deq_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.io_deq_valid) && n < 500) begin
      n++;
      @(negedge clock);
    end
    chk("drain", OUT_W'(exp_q.size()), OUT_W'(0));
    @(posedge clock);
    #1;
  endtask

  initial begin
    int t0;
    int dummy;
    logic done;

    bus.io_enq_valid = 1'b0;
    bus.io_enq_last  = 1'b0;
    bus.io_enq_bits  = '0;
    bus.io_deq_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_valid", OUT_W'(bus.io_deq_valid), OUT_W'(0));
    chk("rst_last", OUT_W'(bus.io_deq_last), OUT_W'(0));
    chk("rst_bits", bus.io_deq_bits, '0);
    chk("rst_ready", OUT_W'(bus.io_enq_ready), OUT_W'(1));
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // 1: single beat of 0..15
    vld_cycles = 0;
    rdy_low    = 0;
    for (int i = 0; i < RATIO; i++) send_word(IN_W'(i), 1'b0, dummy);
    idle();
    repeat (3) @(negedge clock);
    chk("t1_vld_cycles", OUT_W'(vld_cycles), OUT_W'(1));
    chk("t1_rdy_low", OUT_W'(rdy_low), OUT_W'(0));
    drain();

    // 2: 48 words back to back, beats every 16 cycles
    fire_q.delete();
    rdy_low = 0;
    for (int i = 0; i < 3 * RATIO; i++) begin
      send_word(IN_W'(64'h1000 + i), 1'b0, t0);
      if (i == 0) dummy = t0;
    end
    idle();
    repeat (3) @(negedge clock);
    chk("t2_beats", OUT_W'(fire_q.size()), OUT_W'(3));
    for (int k = 0; k < 3 && k < fire_q.size(); k++)
      chk("t2_timing", OUT_W'(fire_q[k] - dummy), OUT_W'(RATIO * (k + 1)));
    chk("t2_rdy_low", OUT_W'(rdy_low), OUT_W'(0));
    drain();

    // 3: backpressure, one beat parked behind a held one
    bus.io_deq_ready = 1'b0;
    for (int i = 0; i < 2 * RATIO; i++) send_word(IN_W'(64'h100 + i), 1'b0, dummy);
    idle();
    @(negedge clock);
    chk("t3_ready_low", OUT_W'(bus.io_enq_ready), OUT_W'(0));
    chk("t3_a_lane0", OUT_W'(bus.io_deq_bits[IN_W-1:0]), OUT_W'(64'h100));
    @(posedge clock);
    #1;
    bus.io_deq_ready = 1'b1;
    @(negedge clock);
    chk("t3_ready_still_low", OUT_W'(bus.io_enq_ready), OUT_W'(0));
    @(negedge clock);
    chk("t3_ready_back", OUT_W'(bus.io_enq_ready), OUT_W'(1));
    chk("t3_b_lane0", OUT_W'(bus.io_deq_bits[IN_W-1:0]), OUT_W'(64'h110));
    @(posedge clock);
    #1;
    drain();

    // 4: short frame, then a one-word frame on lane 0
    for (int i = 0; i < 5; i++) send_word(IN_W'(64'hAA + i), i == 4, dummy);
    send_word(IN_W'(64'h5A5A), 1'b1, dummy);
    idle();
    drain();

    // 5: asynchronous reset with a beat held and a partial beat assembling
    bus.io_deq_ready = 1'b0;
    for (int i = 0; i < RATIO + 7; i++) send_word(IN_W'(64'h300 + i), 1'b0, dummy);
    idle();
    reset = 1'b0;
    #1;
    chk("t5_valid", OUT_W'(bus.io_deq_valid), OUT_W'(0));
    chk("t5_ready", OUT_W'(bus.io_enq_ready), OUT_W'(1));
    chk("t5_bits", bus.io_deq_bits, '0);
    chk("t5_last", OUT_W'(bus.io_deq_last), OUT_W'(0));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    bus.io_deq_ready = 1'b1;
    for (int i = 0; i < RATIO; i++) send_word(IN_W'(64'h200 + i), 1'b0, dummy);
    idle();
    drain();

    // 6: random valid/ready over 10000 words
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(3) == 0) begin
            idle();
            repeat ($urandom_range(2, 1)) @(posedge clock);
            #1;
          end
          send_word({$urandom, $urandom}, $urandom_range(19) == 0, dummy);
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1;
          bus.io_deq_ready = ($urandom_range(3) != 0);
        end
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
